// File: rtl/cf_bank_map_pipe.sv
// rtl/cf_bank_map_pipe.sv - Two-stage conflict-free bank mapper with conflict detection and counter
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   in_valid/in_ready  input beat handshake; mode, lane_en, old_addr travel with the beat
//   out_valid/out_ready output beat handshake; new_addr, bank_num, lane_en_o, conflict travel with it
//   conflict_cnt       saturating count of delivered conflicting beats
//   cnt_clr            synchronous clear of conflict_cnt (wins over increment)
module cf_bank_map_pipe #(
   parameter int ADDR_W = 10,
   parameter int LOG_P  = 2,
   parameter int CNT_W  = 16
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic                                  mode,
   input  logic [(1<<LOG_P)-1:0]                 lane_en,
   input  logic [(1<<LOG_P)*ADDR_W-1:0]          old_addr,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [(1<<LOG_P)*(ADDR_W-LOG_P)-1:0]  new_addr,
   output logic [(1<<LOG_P)*LOG_P-1:0]           bank_num,
   output logic [(1<<LOG_P)-1:0]                 lane_en_o,
   output logic                                  conflict,
   output logic [CNT_W-1:0]                      conflict_cnt,
   input  logic                                  cnt_clr
);

   localparam int P     = 1 << LOG_P;
   localparam int NA_W  = ADDR_W - LOG_P;
   localparam int D     = (ADDR_W + LOG_P - 1) / LOG_P;
   localparam int PAD_W = D * LOG_P;

   // Per-lane address split: in-bank address, digit-sum bank, low-order bank
   logic [PAD_W-1:0]    padded;
   logic [LOG_P-1:0]    dsum;
   logic [P*NA_W-1:0]   in_naddr;
   logic [P*LOG_P-1:0]  in_dsum;
   logic [P*LOG_P-1:0]  in_lowb;

   always_comb begin
      padded   = '0;
      dsum     = '0;
      in_naddr = '0;
      in_dsum  = '0;
      in_lowb  = '0;
      for (int i = 0; i < P; i++) begin
         // zero-extend so the top digit is complete
         padded = PAD_W'(old_addr[i*ADDR_W +: ADDR_W]);
         dsum   = '0;
         // LOG_P-bit accumulator: the sum wraps, giving mod P for free
         for (int d = 0; d < D; d++) begin
            dsum = dsum + padded[d*LOG_P +: LOG_P];
         end
         in_dsum[i*LOG_P +: LOG_P] = dsum;
         in_lowb[i*LOG_P +: LOG_P] = padded[LOG_P-1:0];
         in_naddr[i*NA_W +: NA_W]  = padded[ADDR_W-1:LOG_P];
      end
   end

   // Advance chain: a stage may load when it is empty or the next stage moves
   logic s1_valid;
   logic s2_adv;
   logic s1_adv;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;

   // Stage 1: both bank candidates are held and mode picks between them here
   logic [P*NA_W-1:0]   s1_naddr;
   logic [P*LOG_P-1:0]  s1_dsum;
   logic [P*LOG_P-1:0]  s1_lowb;
   logic [P-1:0]        s1_en;
   logic                s1_mode;
   logic [P*LOG_P-1:0]  s1_bank;
   logic                s1_conflict;

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_naddr <= '0;
         s1_dsum  <= '0;
         s1_lowb  <= '0;
         s1_en    <= '0;
         s1_mode  <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_naddr <= in_naddr;
            s1_dsum  <= in_dsum;
            s1_lowb  <= in_lowb;
            s1_en    <= lane_en;
            s1_mode  <= mode;
         end
      end
   end

   assign s1_bank = s1_mode ? s1_lowb : s1_dsum;

   always_comb begin
      s1_conflict = 1'b0;
      for (int i = 0; i < P; i++) begin
         for (int j = i + 1; j < P; j++) begin
            if (s1_en[i] && s1_en[j] &&
                (s1_bank[i*LOG_P +: LOG_P] == s1_bank[j*LOG_P +: LOG_P])) begin
               s1_conflict = 1'b1;
            end
         end
      end
   end

   // Stage 2: output registers, held while stalled
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid <= 1'b0;
         new_addr  <= '0;
         bank_num  <= '0;
         lane_en_o <= '0;
         conflict  <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            new_addr  <= s1_naddr;
            bank_num  <= s1_bank;
            lane_en_o <= s1_en;
            conflict  <= s1_conflict;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         conflict_cnt <= '0;
      end else if (cnt_clr) begin
         conflict_cnt <= '0;
      end else if (out_valid && out_ready && conflict &&
                   (conflict_cnt != {CNT_W{1'b1}})) begin
         conflict_cnt <= conflict_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_cf_bank_map_pipe.sv
// tb/tb_cf_bank_map_pipe.sv - Self-checking bench for cf_bank_map_pipe
module tb_cf_bank_map_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready, in_ready_2;
   logic        mode;
   logic [3:0]  lane_en;
   logic [39:0] old_addr;
   logic        out_valid, out_valid_2;
   logic        out_ready;
   logic [31:0] new_addr, new_addr_2;
   logic [7:0]  bank_num, bank_num_2;
   logic [3:0]  lane_en_o, lane_en_o_2;
   logic        conflict, conflict_2;
   logic [15:0] conflict_cnt;
   logic [1:0]  conflict_cnt_2;
   logic        cnt_clr;

   always #5 clk = ~clk;

   cf_bank_map_pipe #(.ADDR_W(10), .LOG_P(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
      .lane_en(lane_en), .old_addr(old_addr), .out_valid(out_valid), .out_ready(out_ready),
      .new_addr(new_addr), .bank_num(bank_num), .lane_en_o(lane_en_o), .conflict(conflict),
      .conflict_cnt(conflict_cnt), .cnt_clr(cnt_clr));

   cf_bank_map_pipe #(.ADDR_W(10), .LOG_P(2), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_2), .mode(mode),
      .lane_en(lane_en), .old_addr(old_addr), .out_valid(out_valid_2), .out_ready(out_ready),
      .new_addr(new_addr_2), .bank_num(bank_num_2), .lane_en_o(lane_en_o_2), .conflict(conflict_2),
      .conflict_cnt(conflict_cnt_2), .cnt_clr(cnt_clr));

   typedef struct packed {
      logic [31:0] na;
      logic [7:0]  bk;
      logic [3:0]  en;
      logic        cf;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cnt_m = 0;
   int          cnt2_m = 0;
   logic        last_ihs = 1'b0;
   logic        prev_stall = 1'b0;
   logic [45:0] prev_out = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference: addresses as base-P numbers; bank is the digit sum mod P or the last digit
   function automatic exp_t model(input logic m, input logic [3:0] en, input logic [39:0] a);
      exp_t r;
      int   bk[4];
      r = '0;
      for (int i = 0; i < 4; i++) begin
         int v = int'(a[i*10 +: 10]);
         int s = 0;
         r.na[i*8 +: 8] = 8'(v / 4);
         if (m) bk[i] = v % 4;
         else begin
            while (v > 0) begin
               s += v % 4;
               v = v / 4;
            end
            bk[i] = s % 4;
         end
         r.bk[i*2 +: 2] = 2'(bk[i]);
      end
      r.en = en;
      for (int i = 0; i < 4; i++)
         for (int j = i + 1; j < 4; j++)
            if (en[i] && en[j] && bk[i] == bk[j]) r.cf = 1'b1;
      return r;
   endfunction

   // One clock: check outputs at the falling edge, update the model, return 1ns after the rising edge
   task automatic step();
      logic ihs, ohs;
      exp_t e;
      @(negedge clk);
      ihs = in_valid && in_ready;
      ohs = out_valid && out_ready;
      chk("conflict_cnt", conflict_cnt, cnt_m);
      chk("conflict_cnt_w2", conflict_cnt_2, cnt2_m);
      chk("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
      if (prev_stall)
         chk("stall_hold", {out_valid, new_addr, bank_num, lane_en_o, conflict}, prev_out);
      e = '0;
      if (out_valid) begin
         if (exp_q.size() == 0) chk("spurious_out", out_valid, 1'b0);
         else begin
            e = exp_q[0];
            chk("new_addr", new_addr, e.na);
            chk("bank_num", bank_num, e.bk);
            chk("lane_en_o", lane_en_o, e.en);
            chk("conflict", conflict, e.cf);
            chk("bank_num_w2", bank_num_2, e.bk);
         end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, new_addr, bank_num, lane_en_o, conflict};
      last_ihs   = ihs && rst;
      if (!rst) begin
         exp_q.delete();
         cnt_m = 0;
         cnt2_m = 0;
         prev_stall = 1'b0;
      end else begin
         if (cnt_clr) begin
            cnt_m = 0;
            cnt2_m = 0;
         end else if (ohs && e.cf) begin
            if (cnt_m < 65535) cnt_m++;
            if (cnt2_m < 3) cnt2_m++;
         end
         if (ohs && exp_q.size() > 0) void'(exp_q.pop_front());
         if (ihs) exp_q.push_back(model(mode, lane_en, old_addr));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input logic m, input logic [3:0] en, input logic [39:0] a);
      mode = m;
      lane_en = en;
      old_addr = a;
   endtask

   task automatic send();
      in_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         if (last_ihs) break;
      end
      in_valid = 1'b0;
      chk("accept_timeout", last_ihs, 1'b1);
   endtask

   // Directed beat into an empty pipe with out_ready high: 2-cycle latency and fixed expectations
   task automatic directed(input logic m, input logic [3:0] en, input logic [39:0] a,
                           input logic [7:0] ebk, input logic [31:0] ena, input logic ecf);
      out_ready = 1'b1;
      set_beat(m, en, a);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("lat1_valid", out_valid, 1'b0);
      step();
      chk("lat2_valid", out_valid, 1'b1);
      chk("dir_bank", bank_num, ebk);
      chk("dir_new_addr", new_addr, ena);
      chk("dir_conflict", conflict, ecf);
      chk("dir_lane_en", lane_en_o, en);
      step();
   endtask

   initial begin
      int sent;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
      mode = 1'b0; lane_en = '0; old_addr = '0;
      #1;
      step();
      step();
      rst = 1'b1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_cnt", conflict_cnt, 16'd0);
      chk("rst_outputs", {new_addr, bank_num, lane_en_o, conflict}, 45'd0);

      // Unit stride, stride 4 in both modes
      directed(1'b0, 4'hF, {10'd3, 10'd2, 10'd1, 10'd0}, 8'hE4, 32'h0, 1'b0);
      directed(1'b0, 4'hF, {10'h00C, 10'h008, 10'h004, 10'h000}, 8'hE4, 32'h03020100, 1'b0);
      directed(1'b1, 4'hF, {10'h00C, 10'h008, 10'h004, 10'h000}, 8'h00, 32'h03020100, 1'b1);
      chk("cnt_after_mode1", conflict_cnt, 16'd1);

      // Digit-sum wrap and lane masking
      directed(1'b0, 4'h1, {10'h000, 10'h000, 10'h000, 10'h3FF}, 8'h03, 32'h000000FF, 1'b0);
      directed(1'b0, 4'h3, {10'h002, 10'h002, 10'h004, 10'h001}, 8'hA5, 32'h00000100, 1'b1);
      directed(1'b0, 4'hF, {10'h002, 10'h002, 10'h004, 10'h001}, 8'hA5, 32'h00000100, 1'b1);
      directed(1'b0, 4'h1, {10'h002, 10'h002, 10'h004, 10'h001}, 8'hA5, 32'h00000100, 1'b0);

      // Saturation of the 2-bit counter after 5 conflicting beats
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      chk("clr_cnt_w2", conflict_cnt_2, 2'd0);
      set_beat(1'b1, 4'hF, {10'h00C, 10'h008, 10'h004, 10'h000});
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) step();
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) step();
      chk("sat_cnt_w2", conflict_cnt_2, 2'd3);
      chk("cnt_w16", conflict_cnt, 16'd5);

      // Clear wins over a simultaneous conflicting handshake
      send();
      step();
      chk("clr_race_valid", out_valid, 1'b1);
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      chk("clr_race_cnt", conflict_cnt, 16'd0);
      chk("clr_race_cnt_w2", conflict_cnt_2, 2'd0);

      // Reset with a full pipeline and a nonzero counter
      directed(1'b1, 4'hF, '0, 8'h00, 32'h0, 1'b1);
      out_ready = 1'b0;
      set_beat(1'b0, 4'hF, {10'd7, 10'd6, 10'd5, 10'd4});
      send();
      set_beat(1'b1, 4'hF, {10'd9, 10'd9, 10'd9, 10'd9});
      send();
      chk("full_in_ready", in_ready, 1'b0);
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_cnt", conflict_cnt, 16'd0);
      chk("midrst_in_ready", in_ready, 1'b1);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) step();

      // Random traffic with random backpressure and occasional clears
      sent = 0;
      for (int c = 0; c < 600 && sent < 40; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 2) != 0);
         cnt_clr   = ($urandom_range(0, 15) == 0);
         mode      = 1'($urandom_range(0, 1));
         lane_en   = 4'($urandom);
         old_addr  = 40'({$urandom, $urandom});
         step();
         if (last_ihs) sent++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      cnt_clr = 1'b0;
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) step();
      chk("random_sent", sent, 40);
      chk("drain_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
